// File: rtl/vl_result_collector.sv
// Write-back result collector: counts lane-masked result beats and partial-result
// strobes for one vector instruction, checks masks against vl and flags completion.
module vl_result_collector #(
  parameter int unsigned MAX_VL_PER_LANE = 256,
  parameter int unsigned VLANE_NUM       = 8
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          start_i,
  input  logic [$clog2(VLANE_NUM*MAX_VL_PER_LANE)-1:0]  vl_i,
  input  logic                                          reduction_i,
  input  logic [VLANE_NUM-1:0]                          valid_i,
  input  logic                                          partial_valid_i,
  output logic                                          ready_o,
  output logic                                          busy_o,
  output logic                                          done_o,
  output logic                                          err_o,
  output logic [$clog2(VLANE_NUM*MAX_VL_PER_LANE)-1:0]  elem_cnt_o,
  output logic [$clog2(VLANE_NUM*MAX_VL_PER_LANE)-1:0]  wr_idx_o
);

  localparam int unsigned VL_W   = $clog2(VLANE_NUM*MAX_VL_PER_LANE);
  localparam int unsigned LANE_W = $clog2(VLANE_NUM);
  localparam int unsigned BEAT_W = $clog2(MAX_VL_PER_LANE);
  localparam int unsigned CNT_W  = LANE_W + 1;
  localparam int unsigned SUM_W  = VL_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_PARTIAL = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   div_q, div_d;
  logic [LANE_W-1:0]   mod_q, mod_d;
  logic [BEAT_W-1:0]   last_beat_q, last_beat_d;
  logic [LANE_W-1:0]   pexp_q, pexp_d;
  logic                red_q, red_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [LANE_W-1:0]   pcnt_q, pcnt_d;
  logic [VL_W-1:0]     elem_cnt_q, elem_cnt_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [BEAT_W-1:0]   start_div;
  logic [LANE_W-1:0]   start_mod;
  logic [VLANE_NUM-1:0] exp_mask;
  logic [SUM_W-1:0]    elem_sum;

  function automatic logic [CNT_W-1:0] popcount(input logic [VLANE_NUM-1:0] m);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(VLANE_NUM); i++) begin
      cnt = cnt + CNT_W'(m[i]);
    end
    return cnt;
  endfunction

  // Per-beat helpers: start-time split of vl, expected mask and saturating element sum
  always_comb begin
    start_div = BEAT_W'(vl_i >> LANE_W);
    start_mod = vl_i[LANE_W-1:0];
    for (int i = 0; i < int'(VLANE_NUM); i++) begin
      exp_mask[i] = (beat_cnt_q < div_q) || (LANE_W'(i) < mod_q);
    end
    elem_sum = SUM_W'(elem_cnt_q) + SUM_W'(popcount(valid_i));
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    mod_d       = mod_q;
    last_beat_d = last_beat_q;
    pexp_d      = pexp_q;
    red_d       = red_q;
    beat_cnt_d  = beat_cnt_q;
    pcnt_d      = pcnt_q;
    elem_cnt_d  = elem_cnt_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          div_d       = start_div;
          mod_d       = start_mod;
          red_d       = reduction_i;
          last_beat_d = (start_mod == '0) ? start_div - BEAT_W'(1) : start_div;
          pexp_d      = (start_div != '0) ? LANE_W'(VLANE_NUM - 1) : start_mod - LANE_W'(1);
          beat_cnt_d  = '0;
          pcnt_d      = '0;
          elem_cnt_d  = '0;
          err_d       = 1'b0;
          state_d     = (vl_i == '0) ? S_DONE : S_COLLECT;
        end else if ((valid_i != '0) || partial_valid_i) begin
          err_d = 1'b1;
        end
      end
      S_COLLECT: begin
        if (partial_valid_i) begin
          err_d = 1'b1;
        end
        if (valid_i != '0) begin
          if (valid_i != exp_mask) begin
            err_d = 1'b1;
          end
          elem_cnt_d = elem_sum[VL_W] ? '1 : elem_sum[VL_W-1:0];
          if (beat_cnt_q == last_beat_q) begin
            state_d = (red_q && (pexp_q != '0)) ? S_PARTIAL : S_DONE;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end
      S_PARTIAL: begin
        if (valid_i != '0) begin
          err_d = 1'b1;
        end
        if (partial_valid_i) begin
          pcnt_d = pcnt_q + LANE_W'(1);
          if (pcnt_d == pexp_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_COLLECT) || (state_d == S_PARTIAL);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      mod_q       <= '0;
      last_beat_q <= '0;
      pexp_q      <= '0;
      red_q       <= 1'b0;
      beat_cnt_q  <= '0;
      pcnt_q      <= '0;
      elem_cnt_q  <= '0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      mod_q       <= mod_d;
      last_beat_q <= last_beat_d;
      pexp_q      <= pexp_d;
      red_q       <= red_d;
      beat_cnt_q  <= beat_cnt_d;
      pcnt_q      <= pcnt_d;
      elem_cnt_q  <= elem_cnt_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ready_o    = ready_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign elem_cnt_o = elem_cnt_q;
  assign wr_idx_o   = VL_W'(beat_cnt_q) << LANE_W;

endmodule
